// File: rtl/dma_engine.sv
// Bidirectional DMA between word-addressed memory and a staging buffer.
// Read mode tolerates a pipelined memory read latency; write mode streams one word per cycle.
module dma_engine #(
  parameter int BUFFER_SIZE       = 120,
  parameter int WORD_SIZE         = 16,
  parameter int MEM_ADDRESS_WIDTH = 16,
  parameter int MEM_LATENCY       = 1,
  parameter int COUNT_WIDTH       = $clog2(BUFFER_SIZE + 1)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               i_start,
  input  logic                               i_write,
  input  logic                               i_abort,
  input  logic [MEM_ADDRESS_WIDTH-1:0]       i_address,
  input  logic [COUNT_WIDTH-1:0]             i_count,
  input  logic [BUFFER_SIZE*WORD_SIZE-1:0]   i_buffer,
  input  logic [WORD_SIZE-1:0]               i_mem_data,
  output logic [MEM_ADDRESS_WIDTH-1:0]       o_mem_addr,
  output logic                               o_mem_we,
  output logic [WORD_SIZE-1:0]               o_mem_wdata,
  output logic [BUFFER_SIZE*WORD_SIZE-1:0]   o_buffer,
  output logic                               o_busy,
  output logic                               o_ready,
  output logic [COUNT_WIDTH-1:0]             o_xfer_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [COUNT_WIDTH-1:0]       ONE       = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0]       BUF_WORDS = COUNT_WIDTH'(BUFFER_SIZE);
  localparam logic [MEM_ADDRESS_WIDTH-1:0] ADDR_ONE  = MEM_ADDRESS_WIDTH'(1);

  state_t                 state;
  logic                   write_q;
  logic [COUNT_WIDTH-1:0] n_q;
  logic [COUNT_WIDTH-1:0] issue_idx;
  logic [COUNT_WIDTH-1:0] n_start;
  logic                   abort_now;
  logic                   issue_read;
  logic                   last_issue;
  logic                   cap_v;
  logic [COUNT_WIDTH-1:0] cap_idx;
  logic                   cap_en;
  logic                   cap_last;

  assign n_start    = (i_count > BUF_WORDS) ? BUF_WORDS : i_count;
  assign abort_now  = i_abort && ((state == ISSUE) || (state == DRAIN));
  assign issue_read = (state == ISSUE) && !write_q;
  assign last_issue = (issue_idx == (n_q - ONE));
  assign cap_en     = cap_v && !abort_now && ((state == ISSUE) || (state == DRAIN));
  assign cap_last   = ((o_xfer_count + ONE) == n_q);

  // Tracks which issue index each returning memory word belongs to.
  if (MEM_LATENCY == 0) begin : g_comb_mem
    assign cap_v   = issue_read;
    assign cap_idx = issue_idx;
  end else begin : g_pipe_mem
    logic [MEM_LATENCY-1:0] pv;
    logic [COUNT_WIDTH-1:0] pidx [MEM_LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pv <= '0;
        for (int j = 0; j < MEM_LATENCY; j++) pidx[j] <= '0;
      end else if (abort_now) begin
        pv <= '0;
      end else begin
        pv[0]   <= issue_read;
        pidx[0] <= issue_idx;
        for (int j = 1; j < MEM_LATENCY; j++) begin
          pv[j]   <= pv[j-1];
          pidx[j] <= pidx[j-1];
        end
      end
    end

    assign cap_v   = pv[MEM_LATENCY-1];
    assign cap_idx = pidx[MEM_LATENCY-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      write_q      <= 1'b0;
      n_q          <= '0;
      issue_idx    <= '0;
      o_mem_addr   <= '0;
      o_mem_we     <= 1'b0;
      o_mem_wdata  <= '0;
      o_buffer     <= '0;
      o_busy       <= 1'b0;
      o_ready      <= 1'b0;
      o_xfer_count <= '0;
    end else begin
      if (cap_en) begin
        o_buffer[cap_idx*WORD_SIZE +: WORD_SIZE] <= i_mem_data;
        o_xfer_count <= o_xfer_count + ONE;
      end
      case (state)
        IDLE: begin
          if (i_start) begin
            write_q      <= i_write;
            n_q          <= n_start;
            issue_idx    <= '0;
            o_ready      <= 1'b0;
            o_busy       <= 1'b1;
            o_xfer_count <= '0;
            if (n_start == '0) begin
              state <= DONE;
            end else begin
              state      <= ISSUE;
              o_mem_addr <= i_address;
              o_mem_we   <= i_write;
              if (i_write) o_mem_wdata <= i_buffer[0 +: WORD_SIZE];
            end
          end
        end
        ISSUE: begin
          if (abort_now) begin
            // A write word on the bus at the abort edge is still committed by memory.
            if (write_q) o_xfer_count <= o_xfer_count + ONE;
            state    <= IDLE;
            o_busy   <= 1'b0;
            o_ready  <= 1'b0;
            o_mem_we <= 1'b0;
          end else if (write_q) begin
            o_xfer_count <= o_xfer_count + ONE;
            if (last_issue) begin
              o_mem_we <= 1'b0;
              state    <= DONE;
              o_busy   <= 1'b0;
              o_ready  <= 1'b1;
            end else begin
              issue_idx   <= issue_idx + ONE;
              o_mem_addr  <= o_mem_addr + ADDR_ONE;
              o_mem_wdata <= i_buffer[(issue_idx + ONE)*WORD_SIZE +: WORD_SIZE];
            end
          end else if (last_issue) begin
            if (MEM_LATENCY == 0) begin
              state   <= DONE;
              o_busy  <= 1'b0;
              o_ready <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end else begin
            issue_idx  <= issue_idx + ONE;
            o_mem_addr <= o_mem_addr + ADDR_ONE;
          end
        end
        DRAIN: begin
          if (abort_now) begin
            state   <= IDLE;
            o_busy  <= 1'b0;
            o_ready <= 1'b0;
          end else if (cap_en && cap_last) begin
            state   <= DONE;
            o_busy  <= 1'b0;
            o_ready <= 1'b1;
          end
        end
        DONE: begin
          // Also reached directly from IDLE for an empty transfer, so complete here too.
          state   <= IDLE;
          o_busy  <= 1'b0;
          o_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_engine.sv
// Bench for dma_engine: three instances (default, tiny wrapping, long latency) against
// behavioural memories and a reference model of buffer and memory contents.
`timescale 1ns/1ps
module tb_dma_engine;

  localparam int W    = 16;
  localparam int BS_A = 120;
  localparam int CW_A = $clog2(BS_A + 1);
  localparam int BS_B = 4;
  localparam int CW_B = $clog2(BS_B + 1);
  localparam int BS_C = 8;
  localparam int CW_C = $clog2(BS_C + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // instance A: defaults (latency 1)
  logic a_start, a_write, a_abort;
  logic [15:0] a_addr;
  logic [CW_A-1:0] a_count;
  logic [BS_A*W-1:0] a_ibuf, a_obuf;
  logic [W-1:0] a_mdata, a_wdata;
  logic [15:0] a_maddr;
  logic a_we, a_busy, a_ready;
  logic [CW_A-1:0] a_xfer;

  // instance B: 3-bit addresses, 4-word buffer, combinational memory
  logic b_start, b_write, b_abort;
  logic [2:0] b_addr, b_maddr;
  logic [CW_B-1:0] b_count, b_xfer;
  logic [BS_B*W-1:0] b_ibuf, b_obuf;
  logic [W-1:0] b_mdata, b_wdata;
  logic b_we, b_busy, b_ready;

  // instance C: 8-word buffer, latency 3
  logic c_start, c_write, c_abort;
  logic [15:0] c_addr, c_maddr;
  logic [CW_C-1:0] c_count, c_xfer;
  logic [BS_C*W-1:0] c_ibuf, c_obuf;
  logic [W-1:0] c_mdata, c_wdata, c_p1, c_p2;
  logic c_we, c_busy, c_ready;

  dma_engine #(.BUFFER_SIZE(BS_A), .WORD_SIZE(W), .MEM_ADDRESS_WIDTH(16), .MEM_LATENCY(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .i_start(a_start), .i_write(a_write), .i_abort(a_abort),
    .i_address(a_addr), .i_count(a_count), .i_buffer(a_ibuf), .i_mem_data(a_mdata),
    .o_mem_addr(a_maddr), .o_mem_we(a_we), .o_mem_wdata(a_wdata), .o_buffer(a_obuf),
    .o_busy(a_busy), .o_ready(a_ready), .o_xfer_count(a_xfer));

  dma_engine #(.BUFFER_SIZE(BS_B), .WORD_SIZE(W), .MEM_ADDRESS_WIDTH(3), .MEM_LATENCY(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_start(b_start), .i_write(b_write), .i_abort(b_abort),
    .i_address(b_addr), .i_count(b_count), .i_buffer(b_ibuf), .i_mem_data(b_mdata),
    .o_mem_addr(b_maddr), .o_mem_we(b_we), .o_mem_wdata(b_wdata), .o_buffer(b_obuf),
    .o_busy(b_busy), .o_ready(b_ready), .o_xfer_count(b_xfer));

  dma_engine #(.BUFFER_SIZE(BS_C), .WORD_SIZE(W), .MEM_ADDRESS_WIDTH(16), .MEM_LATENCY(3)) dut_c (
    .clk(clk), .rst_n(rst_n), .i_start(c_start), .i_write(c_write), .i_abort(c_abort),
    .i_address(c_addr), .i_count(c_count), .i_buffer(c_ibuf), .i_mem_data(c_mdata),
    .o_mem_addr(c_maddr), .o_mem_we(c_we), .o_mem_wdata(c_wdata), .o_buffer(c_obuf),
    .o_busy(c_busy), .o_ready(c_ready), .o_xfer_count(c_xfer));

  // behavioural memories
  logic [W-1:0] mem_a [65536];
  logic [W-1:0] ref_a [65536];
  logic [W-1:0] eb_a  [BS_A];
  logic [W-1:0] mem_b [8];
  logic [W-1:0] mem_c [65536];
  logic [W-1:0] exp_q [$];

  always @(posedge clk) begin
    a_mdata <= mem_a[a_maddr];
    if (a_we) mem_a[a_maddr] = a_wdata;
  end

  assign b_mdata = mem_b[b_maddr];
  always @(posedge clk) if (b_we) mem_b[b_maddr] = b_wdata;

  always @(posedge clk) begin
    c_p1    <= mem_c[c_maddr];
    c_p2    <= c_p1;
    c_mdata <= c_p2;
    if (c_we) mem_c[c_maddr] = c_wdata;
  end

  function automatic logic [W-1:0] c_word(input int a);
    return W'(a * 3 + 7);
  endfunction

  // reference model for instance A: what the buffer and memory must look like afterwards
  task automatic model_a(input bit wr, input logic [15:0] addr, input int cnt);
    int n;
    n = (cnt > BS_A) ? BS_A : cnt;
    for (int k = 0; k < n; k++) begin
      if (wr) ref_a[16'(addr + k)] = a_ibuf[k*W +: W];
      else    eb_a[k] = ref_a[16'(addr + k)];
    end
  endtask

  function automatic int first_bad_a();
    for (int k = 0; k < BS_A; k++) if (a_obuf[k*W +: W] !== eb_a[k]) return k;
    return -1;
  endfunction

  task automatic go_a(input bit wr, input logic [15:0] addr, input int cnt);
    a_write = wr; a_addr = addr; a_count = CW_A'(cnt); a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    a_write = 1'($urandom); a_addr = 16'($urandom); a_count = CW_A'($urandom);
  endtask

  // Runs until busy falls (bounded), then steps into the following IDLE cycle.
  task automatic wait_a(input int budget, output int busy_cyc, output int we_cyc, output int moves);
    logic [15:0] a0;
    a0 = a_maddr; busy_cyc = 0; we_cyc = 0; moves = 0;
    while (a_busy === 1'b1 && busy_cyc <= budget) begin
      busy_cyc++;
      if (a_we === 1'b1) we_cyc++;
      if (a_maddr !== a0) moves++;
      @(posedge clk); #1;
    end
    if (a_we === 1'b1) we_cyc++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    n_checks++; if (a_busy !== 1'b0 || a_ready !== 1'b0 || a_we !== 1'b0) $display("FAIL reset_flags: got busy=%b ready=%b we=%b exp 0 0 0", a_busy, a_ready, a_we); else n_pass++;
    n_checks++; if (a_maddr !== 16'd0 || a_wdata !== 16'd0) $display("FAIL reset_bus: got addr=%0d wdata=%0d exp 0 0", a_maddr, a_wdata); else n_pass++;
    n_checks++; if (a_xfer !== '0) $display("FAIL reset_xfer: got %0d exp 0", a_xfer); else n_pass++;
    n_checks++; if (a_obuf !== '0 || b_obuf !== '0 || c_obuf !== '0) $display("FAIL reset_buffer: buffers not all zero"); else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_read_basic();
    int bc, wc, mv, bad;
    model_a(1'b0, 16'd1, 4);
    go_a(1'b0, 16'd1, 4);
    wait_a(200, bc, wc, mv);
    n_checks++; if (bc !== 5) $display("FAIL read_busy_cycles: got %0d exp 5", bc); else n_pass++;
    n_checks++; if (wc !== 0) $display("FAIL read_we_cycles: got %0d exp 0", wc); else n_pass++;
    n_checks++; if (a_ready !== 1'b1 || a_busy !== 1'b0) $display("FAIL read_ready: got ready=%b busy=%b exp 1 0", a_ready, a_busy); else n_pass++;
    n_checks++; if (a_xfer !== CW_A'(4)) $display("FAIL read_xfer: got %0d exp 4", a_xfer); else n_pass++;
    bad = first_bad_a();
    n_checks++; if (bad >= 0) $display("FAIL read_buffer: word %0d got %h exp %h", bad, a_obuf[bad*W +: W], eb_a[bad]); else n_pass++;
  endtask

  task automatic test_write();
    int bc, wc, mv, bad;
    for (int k = 0; k < BS_A; k++) a_ibuf[k*W +: W] = W'($urandom);
    a_ibuf[0 +: W] = 16'hAAAA; a_ibuf[W +: W] = 16'hBBBB; a_ibuf[2*W +: W] = 16'hCCCC;
    model_a(1'b1, 16'd10, 3);
    go_a(1'b1, 16'd10, 3);
    wait_a(200, bc, wc, mv);
    n_checks++; if (wc !== 3 || bc !== 3) $display("FAIL write_cycles: got we=%0d busy=%0d exp 3 3", wc, bc); else n_pass++;
    n_checks++; if (mem_a[10] !== 16'hAAAA || mem_a[11] !== 16'hBBBB || mem_a[12] !== 16'hCCCC) $display("FAIL write_mem: got %h %h %h exp aaaa bbbb cccc", mem_a[10], mem_a[11], mem_a[12]); else n_pass++;
    n_checks++; if (mem_a[13] !== ref_a[13]) $display("FAIL write_mem_after: got %h exp %h", mem_a[13], ref_a[13]); else n_pass++;
    bad = first_bad_a();
    n_checks++; if (bad >= 0) $display("FAIL write_buffer_untouched: word %0d got %h exp %h", bad, a_obuf[bad*W +: W], eb_a[bad]); else n_pass++;
    n_checks++; if (a_xfer !== CW_A'(3) || a_ready !== 1'b1) $display("FAIL write_done: got xfer=%0d ready=%b exp 3 1", a_xfer, a_ready); else n_pass++;
  endtask

  task automatic test_zero_count();
    int bc, wc, mv;
    go_a(1'b0, 16'd50, 0);
    wait_a(50, bc, wc, mv);
    n_checks++; if (mv !== 0 || wc !== 0) $display("FAIL zero_no_access: got moves=%0d we=%0d exp 0 0", mv, wc); else n_pass++;
    n_checks++; if (bc !== 1) $display("FAIL zero_busy_cycles: got %0d exp 1", bc); else n_pass++;
    n_checks++; if (a_ready !== 1'b1 || a_xfer !== '0) $display("FAIL zero_done: got ready=%b xfer=%0d exp 1 0", a_ready, a_xfer); else n_pass++;
  endtask

  task automatic test_start_ignored();
    int bc, bc2, wc, mv, bad;
    model_a(1'b0, 16'd300, 100);
    go_a(1'b0, 16'd300, 100);
    bc = 0;
    a_write = 1'b1; a_addr = 16'd7; a_count = CW_A'(5);
    for (int i = 0; i < 12; i++) begin
      if (a_busy === 1'b1) bc++;
      a_start = (i == 10);
      @(posedge clk); #1;
    end
    a_start = 1'b0;
    wait_a(300, bc2, wc, mv);
    n_checks++; if (bc + bc2 !== 101) $display("FAIL ignore_busy_cycles: got %0d exp 101", bc + bc2); else n_pass++;
    n_checks++; if (wc !== 0 || a_xfer !== CW_A'(100)) $display("FAIL ignore_xfer: got we=%0d xfer=%0d exp 0 100", wc, a_xfer); else n_pass++;
    bad = first_bad_a();
    n_checks++; if (bad >= 0) $display("FAIL ignore_buffer: word %0d got %h exp %h", bad, a_obuf[bad*W +: W], eb_a[bad]); else n_pass++;
    repeat (3) @(posedge clk); #1;
    n_checks++; if (a_busy !== 1'b0) $display("FAIL ignore_no_second: got busy=%b exp 0", a_busy); else n_pass++;
  endtask

  task automatic test_wrap_clamp();
    logic [W-1:0] got_q [$];
    int bad, guard;
    exp_q = {};
    for (int k = 0; k < 4; k++) exp_q.push_back(W'((6 + k) % 8));
    b_addr = 3'd6; b_count = CW_B'(6); b_write = 1'b0; b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0; b_addr = 3'd2; b_count = CW_B'(1);
    guard = 0;
    while (b_busy === 1'b1 && guard < 20) begin
      got_q.push_back(W'(b_maddr));
      guard++;
      @(posedge clk); #1;
    end
    n_checks++; if (got_q.size() !== exp_q.size()) $display("FAIL wrap_addr_count: got %0d exp %0d", got_q.size(), exp_q.size()); else n_pass++;
    bad = -1;
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) if (got_q[k] !== exp_q[k] && bad < 0) bad = k;
    n_checks++; if (bad >= 0) $display("FAIL wrap_addr_seq: issue %0d got %0d exp %0d", bad, got_q[bad], exp_q[bad]); else n_pass++;
    bad = -1;
    for (int k = 0; k < BS_B; k++) if (b_obuf[k*W +: W] !== exp_q[k] && bad < 0) bad = k;
    n_checks++; if (bad >= 0) $display("FAIL wrap_buffer: word %0d got %0d exp %0d", bad, b_obuf[bad*W +: W], exp_q[bad]); else n_pass++;
    n_checks++; if (b_xfer !== CW_B'(4) || b_ready !== 1'b1) $display("FAIL wrap_done: got xfer=%0d ready=%b exp 4 1", b_xfer, b_ready); else n_pass++;
  endtask

  task automatic test_abort();
    logic [W-1:0] exp_c [BS_C];
    int bc, bad;
    c_addr = 16'd100; c_count = CW_C'(8); c_start = 1'b1;
    @(posedge clk); #1;
    c_start = 1'b0;
    bc = 0;
    while (c_busy === 1'b1 && bc < 40) begin bc++; @(posedge clk); #1; end
    for (int k = 0; k < BS_C; k++) exp_c[k] = c_word(100 + k);
    n_checks++; if (bc !== 11) $display("FAIL lat3_busy_cycles: got %0d exp 11", bc); else n_pass++;
    bad = -1;
    for (int k = 0; k < BS_C; k++) if (c_obuf[k*W +: W] !== exp_c[k] && bad < 0) bad = k;
    n_checks++; if (bad >= 0) $display("FAIL lat3_buffer: word %0d got %h exp %h", bad, c_obuf[bad*W +: W], exp_c[bad]); else n_pass++;
    @(posedge clk); #1;
    c_addr = 16'd500; c_start = 1'b1;
    @(posedge clk); #1;
    c_start = 1'b0;
    repeat (4) @(posedge clk); #1;
    c_abort = 1'b1;
    @(posedge clk); #1;
    c_abort = 1'b0;
    n_checks++; if (c_busy !== 1'b0 || c_ready !== 1'b0) $display("FAIL abort_flags: got busy=%b ready=%b exp 0 0", c_busy, c_ready); else n_pass++;
    exp_c[0] = c_word(500);
    repeat (6) @(posedge clk); #1;
    n_checks++; if (c_xfer !== CW_C'(1) || c_ready !== 1'b0) $display("FAIL abort_xfer: got xfer=%0d ready=%b exp 1 0", c_xfer, c_ready); else n_pass++;
    bad = -1;
    for (int k = 0; k < BS_C; k++) if (c_obuf[k*W +: W] !== exp_c[k] && bad < 0) bad = k;
    n_checks++; if (bad >= 0) $display("FAIL abort_buffer: word %0d got %h exp %h", bad, c_obuf[bad*W +: W], exp_c[bad]); else n_pass++;
  endtask

  task automatic test_reset_mid_write();
    int bc, wc, mv, bad;
    for (int k = 0; k < BS_A; k++) a_ibuf[k*W +: W] = W'($urandom);
    go_a(1'b1, 16'd1000, 20);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) ref_a[1000 + k] = a_ibuf[k*W +: W];
    for (int k = 0; k < BS_A; k++) eb_a[k] = '0;
    n_checks++; if (a_we !== 1'b0 || a_busy !== 1'b0 || a_ready !== 1'b0) $display("FAIL rst_mid_flags: got we=%b busy=%b ready=%b exp 0 0 0", a_we, a_busy, a_ready); else n_pass++;
    n_checks++; if (a_obuf !== '0) $display("FAIL rst_mid_buffer: buffer not zero"); else n_pass++;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (mem_a[1003] !== ref_a[1003] || mem_a[1004] !== ref_a[1004]) $display("FAIL rst_mid_mem: got %h %h exp %h %h", mem_a[1003], mem_a[1004], ref_a[1003], ref_a[1004]); else n_pass++;
    model_a(1'b0, 16'd0, 2);
    go_a(1'b0, 16'd0, 2);
    wait_a(50, bc, wc, mv);
    n_checks++; if (bc !== 3 || a_xfer !== CW_A'(2) || a_ready !== 1'b1) $display("FAIL rst_then_read: got busy=%0d xfer=%0d ready=%b exp 3 2 1", bc, a_xfer, a_ready); else n_pass++;
    bad = first_bad_a();
    n_checks++; if (bad >= 0) $display("FAIL rst_then_buffer: word %0d got %h exp %h", bad, a_obuf[bad*W +: W], eb_a[bad]); else n_pass++;
  endtask

  task automatic test_random_back_to_back();
    int bc, wc, mv, bad, n, cnt, exp_bc;
    bit wr;
    logic [15:0] addr;
    for (int it = 0; it < 25; it++) begin
      wr   = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF0 + $urandom_range(0, 15)) : 16'($urandom_range(0, 2000));
      cnt  = ($urandom_range(0, 7) == 0) ? $urandom_range(118, 127) : $urandom_range(0, 24);
      n    = (cnt > BS_A) ? BS_A : cnt;
      for (int k = 0; k < BS_A; k++) a_ibuf[k*W +: W] = W'($urandom);
      model_a(wr, addr, cnt);
      go_a(wr, addr, cnt);
      wait_a(400, bc, wc, mv);
      exp_bc = (n == 0) ? 1 : (wr ? n : n + 1);
      n_checks++; if (bc !== exp_bc || wc !== (wr ? n : 0)) $display("FAIL rand_cycles it%0d: got busy=%0d we=%0d exp %0d %0d", it, bc, wc, exp_bc, wr ? n : 0); else n_pass++;
      n_checks++; if (a_xfer !== CW_A'(n) || a_ready !== 1'b1) $display("FAIL rand_done it%0d: got xfer=%0d ready=%b exp %0d 1", it, a_xfer, a_ready, n); else n_pass++;
      bad = first_bad_a();
      n_checks++; if (bad >= 0) $display("FAIL rand_buffer it%0d: word %0d got %h exp %h", it, bad, a_obuf[bad*W +: W], eb_a[bad]); else n_pass++;
      if (wr) begin
        bad = -1;
        for (int k = 0; k <= n; k++) if (mem_a[16'(addr + k)] !== ref_a[16'(addr + k)] && bad < 0) bad = k;
        n_checks++; if (bad >= 0) $display("FAIL rand_mem it%0d: offset %0d got %h exp %h", it, bad, mem_a[16'(addr + bad)], ref_a[16'(addr + bad)]); else n_pass++;
      end
    end
  endtask

  initial begin
    a_start = 0; a_write = 0; a_abort = 0; a_addr = '0; a_count = '0; a_ibuf = '0;
    b_start = 0; b_write = 0; b_abort = 0; b_addr = '0; b_count = '0; b_ibuf = '0;
    c_start = 0; c_write = 0; c_abort = 0; c_addr = '0; c_count = '0; c_ibuf = '0;
    for (int i = 0; i < 65536; i++) begin
      mem_a[i] = W'(i); ref_a[i] = W'(i); mem_c[i] = c_word(i);
    end
    for (int i = 0; i < 8; i++) mem_b[i] = W'(i);
    for (int k = 0; k < BS_A; k++) eb_a[k] = '0;
    repeat (3) @(posedge clk);
    test_reset();
    test_read_basic();
    test_write();
    test_zero_count();
    test_start_ignored();
    test_wrap_clamp();
    test_abort();
    test_reset_mid_write();
    test_random_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dma_engine.md
Name: dma_engine

Overview:
Parametrised, bidirectional successor to the accelerator DMA. It moves a run of words between the word-addressed weight/feature memory and a BUFFER_SIZE-word staging buffer. Read mode (memory to buffer) tolerates a configurable pipelined memory read latency. Write mode (buffer to memory) streams one word per cycle. Control is a start/busy/ready handshake with abort; it feeds the FC layer buffers and writes results back.

Parameters:
BUFFER_SIZE, 120, number of words in the staging buffer
WORD_SIZE, 16, bits per word
MEM_ADDRESS_WIDTH, 16, memory address width; addresses wrap modulo 2**MEM_ADDRESS_WIDTH
MEM_LATENCY, 1, clock edges from o_mem_addr to valid i_mem_data (0 = combinational memory)
COUNT_WIDTH, $clog2(BUFFER_SIZE+1), width of the count ports

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
i_start  in  1  start request, sampled only in IDLE
i_write  in  1  mode, sampled with i_start: 0 = read (mem to buffer), 1 = write (buffer to mem)
i_abort  in  1  cancel the transfer in progress
i_address  in  MEM_ADDRESS_WIDTH  first memory address
i_count  in  COUNT_WIDTH  words to move
i_buffer  in  BUFFER_SIZE*WORD_SIZE  source words for write mode (word k = bits [k*WORD_SIZE +: WORD_SIZE])
i_mem_data  in  WORD_SIZE  memory read data
o_mem_addr  out  MEM_ADDRESS_WIDTH  memory address
o_mem_we  out  1  memory write enable
o_mem_wdata  out  WORD_SIZE  memory write data
o_buffer  out  BUFFER_SIZE*WORD_SIZE  staging buffer, same packing as i_buffer
o_busy  out  1  transfer in progress
o_ready  out  1  last transfer completed without abort
o_xfer_count  out  COUNT_WIDTH  words completed in the current/last transfer

Behaviour:
- Reset (rst_n low, async): state IDLE; o_buffer all zero; o_mem_addr 0; o_mem_we 0; o_mem_wdata 0; o_busy 0; o_ready 0; o_xfer_count 0; latency pipeline flushed.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: i_start=1 at edge E0 latches address, mode and N = min(i_count, BUFFER_SIZE). At E0: o_ready cleared, o_xfer_count cleared, o_busy set, go to ISSUE. If N=0, go to DONE instead with no memory access.
- i_start outside IDLE is ignored. Latched parameters are immune to input changes mid-transfer.
- ISSUE, read: drives o_mem_addr = A+k for issue index k = 0..N-1, one per cycle (k presented after E_k). o_mem_we stays 0.
  - The word for index k is captured into o_buffer[k] at E(k+1+MEM_LATENCY). o_xfer_count increments per capture.
  - After the last issue, go to DRAIN. With MEM_LATENCY=0, go directly to DONE.
- DRAIN: waits until all outstanding words are captured, then DONE. The last capture is at E(N+MEM_LATENCY).
- ISSUE, write: drives o_mem_we=1, o_mem_addr=A+k, o_mem_wdata=i_buffer[k] during cycle k. The memory commits at E(k+1). o_xfer_count increments per word. After the last word, o_mem_we=0 and go to DONE (no drain).
- DONE (one cycle): o_busy=0, o_ready=1, go to IDLE. o_ready holds until the next accepted start or reset.
- Address arithmetic wraps modulo 2**MEM_ADDRESS_WIDTH.
- Buffer indices ≥ N are never modified.
- o_buffer is not modified in write mode.
- i_abort while busy:
  - Issuing stops at the next edge; o_mem_we drops.
  - In-flight read data is discarded; words already captured remain.
  - Go to IDLE with o_busy=0, o_ready=0; o_xfer_count holds completed words.
  - Abort in IDLE/DONE has no effect.
  - Abort and start in the same IDLE cycle: start wins.
- Reset mid-transfer: immediate return to reset values, buffer cleared.

Test Plan:
- Memory model mem[i]=i, MEM_LATENCY=1; read A=1, N=4 -> o_buffer[0..3]=1,2,3,4, o_buffer[4..]=0, o_ready rises after E(N+MEM_LATENCY)=E5, o_xfer_count=4, o_busy high for exactly 5 cycles.
- Write A=10, N=3, i_buffer[0..2]=16'hAAAA,16'hBBBB,16'hCCCC -> mem[10..12] hold those values, o_mem_we high exactly 3 cycles, mem[13] unchanged, o_buffer unchanged.
- Wrap and clamp: MEM_ADDRESS_WIDTH=3, BUFFER_SIZE=4, read A=6, i_count=6 -> addresses 6,7,0,1 only, o_buffer = 6,7,0,1, o_xfer_count=4.
- i_count=0 -> no o_mem_addr activity, o_mem_we 0, o_ready high after E1, o_xfer_count=0; i_start pulsed again while busy on a long read -> ignored, single transfer completes.
- Read N=8, MEM_LATENCY=3, i_abort asserted after 4 issues -> o_ready stays 0, o_busy drops next cycle, at most 1 word captured (indices issued ≥3 edges earlier), o_buffer[5..7] untouched.
- rst_n pulsed low mid-write (asynchronously, between edges) -> o_mem_we, o_busy, o_ready drop immediately, o_buffer all zero; a following read of A=0, N=2 completes correctly.
